ir_alu_seq: RTL

//  Sequential, handshaked N-bit integer ALU built from the ir_* primitive ops: add/sub with carry-in, negate, and shifts/rotates.

---
 rtl/ir_alu_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ir_alu_seq.sv
// ir_alu_seq -- sequential, handshaked N-bit integer ALU.
//
// Purpose:
//   Performs ADD/SUB (optional carry/borrow-in from CF), NEG, iterative
//   shifts/rotates (one bit per clock), and the CLRC/SETC carry-flag ops.
//   It keeps an architectural carry flag CF across operations. Requests
//   arrive on a valid/ready pair, and results leave on a second valid/ready
//   pair.
//
// Ports:
//   CLK        clock, rising edge
//   RESETN     synchronous reset, active low
//   IN_VALID   request valid          IN_READY   request can be accepted
//   OP         opcode (0 ADD,1 SUB,2 NEG,3 ASR,4 LSR,5 ROR,6 CLRC,7 SETC)
//   A, B       operands (B: ADD/SUB only)
//   SHAMT      shift amount (ASR/LSR/ROR only)
//   USE_CF     ADD/SUB carry/borrow-in = CF, else 0
//   OUT_VALID  result valid           OUT_READY  consumer accepts result
//   C          result                 COUT       carry/borrow/shift-out
//   CF         architectural carry flag
//
// Configuration:
//   IR_ALU_SEQ_FLAGS_EN  when defined, adds the registered Z (zero) and
//                        V (signed overflow) outputs.
module ir_alu_seq #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          CLK,
  input  logic          RESETN,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [2:0]    OP,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [SW-1:0] SHAMT,
  input  logic          USE_CF,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [N-1:0]  C,
  output logic          COUT,
`ifdef IR_ALU_SEQ_FLAGS_EN
  output logic          Z,
  output logic          V,
`endif
  output logic          CF
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_NEG, OP_ASR, OP_LSR, OP_ROR, OP_CLRC, OP_SETC
  } op_t;

  state_t        state_q;
  logic [N-1:0]  c_q;
  logic          cout_q;
  logic          cf_q;
  logic          ovalid_q;
  logic [SW-1:0] cnt_q;    // shifts still to perform while BUSY
  logic          asr_q;
  logic          rot_q;
`ifdef IR_ALU_SEQ_FLAGS_EN
  logic          z_q;
  logic          v_q;
`endif

  // One right-shift step: returns {bit shifted out, shifted value}.
  function automatic logic [N:0] shift1(input logic [N-1:0] v,
                                        input logic asr, input logic rot);
    logic fill;
    fill = rot ? v[0] : (asr & v[N-1]);
    return {v[0], fill, v[N-1:1]};
  endfunction

  logic          accept;
  logic          cin;
  logic [N:0]    sum;
  logic [N:0]    dif;
  logic [N:0]    sh_acc;
  logic [N:0]    sh_busy;
  logic [N-1:0]  acc_c;
  logic          acc_cout;
  logic          acc_busy;
  logic          op_asr;
  logic          op_rot;
`ifdef IR_ALU_SEQ_FLAGS_EN
  logic          acc_v;
`endif

  assign IN_READY  = RESETN & ((state_q == S_IDLE) |
                               ((state_q == S_DONE) & OUT_READY));
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = ovalid_q;
  assign C         = c_q;
  assign COUT      = cout_q;
  assign CF        = cf_q;
`ifdef IR_ALU_SEQ_FLAGS_EN
  assign Z         = z_q;
  assign V         = v_q;
`endif

  always_comb begin
    cin      = USE_CF & cf_q;
    sum      = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, cin};
    dif      = {1'b0, A} - {1'b0, B} - {{N{1'b0}}, cin};
    op_asr   = (OP == OP_ASR);
    op_rot   = (OP == OP_ROR);
    // The first shift happens on the accepting edge, so latency is
    // max(1, SHAMT) edges.
    sh_acc   = shift1(A, op_asr, op_rot);
    sh_busy  = shift1(c_q, asr_q, rot_q);
    acc_c    = A;
    acc_cout = 1'b0;
    acc_busy = 1'b0;
`ifdef IR_ALU_SEQ_FLAGS_EN
    acc_v    = 1'b0;
`endif
    case (OP)
      OP_ADD: begin
        {acc_cout, acc_c} = sum;
`ifdef IR_ALU_SEQ_FLAGS_EN
        acc_v = (A[N-1] == B[N-1]) & (sum[N-1] != A[N-1]);
`endif
      end
      OP_SUB: begin
        {acc_cout, acc_c} = dif;
`ifdef IR_ALU_SEQ_FLAGS_EN
        acc_v = (A[N-1] != B[N-1]) & (dif[N-1] != A[N-1]);
`endif
      end
      OP_NEG: begin
        acc_c    = -A;
        acc_cout = (A != '0);
`ifdef IR_ALU_SEQ_FLAGS_EN
        acc_v    = (A == {1'b1, {(N-1){1'b0}}});
`endif
      end
      OP_ASR, OP_LSR, OP_ROR: begin
        if (SHAMT == '0) begin
          acc_c    = A;
          acc_cout = cf_q;
        end else begin
          acc_c    = sh_acc[N-1:0];
          acc_cout = sh_acc[N];
          acc_busy = (SHAMT != SW'(1));
        end
      end
      OP_CLRC: acc_cout = 1'b0;
      OP_SETC: acc_cout = 1'b1;
      default: acc_cout = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      cout_q   <= 1'b0;
      cf_q     <= 1'b0;
      ovalid_q <= 1'b0;
      cnt_q    <= '0;
      asr_q    <= 1'b0;
      rot_q    <= 1'b0;
`ifdef IR_ALU_SEQ_FLAGS_EN
      z_q      <= 1'b0;
      v_q      <= 1'b0;
`endif
    end else if (state_q == S_BUSY) begin
      c_q    <= sh_busy[N-1:0];
      cout_q <= sh_busy[N];
      cnt_q  <= cnt_q - SW'(1);
`ifdef IR_ALU_SEQ_FLAGS_EN
      z_q    <= (sh_busy[N-1:0] == '0);
      v_q    <= 1'b0;
`endif
      if (cnt_q == SW'(1)) begin
        state_q  <= S_DONE;
        ovalid_q <= 1'b1;
        cf_q     <= sh_busy[N];
      end
    end else if (accept) begin
      c_q    <= acc_c;
      cout_q <= acc_cout;
      cnt_q  <= SHAMT - SW'(1);
      asr_q  <= op_asr;
      rot_q  <= op_rot;
`ifdef IR_ALU_SEQ_FLAGS_EN
      z_q    <= (acc_c == '0);
      v_q    <= acc_v;
`endif
      if (acc_busy) begin
        state_q  <= S_BUSY;
        ovalid_q <= 1'b0;
      end else begin
        state_q  <= S_DONE;
        ovalid_q <= 1'b1;
        cf_q     <= acc_cout;
      end
    end else if ((state_q == S_DONE) && OUT_READY) begin
      state_q  <= S_IDLE;
      ovalid_q <= 1'b0;
    end
  end

endmodule
